// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the sequential radix-4 multiply controller.
// The early-termination test below is only used when MULT_EARLY_TERM_EN is defined.
package mult_seq_pkg;

    localparam int ITER_COUNT    = 16;
    localparam int BITS_PER_ITER = 2;
    localparam int DATA_W        = 32;
    localparam int ACC_W         = 64;
    localparam int K_W           = $clog2(ITER_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_CORR = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // True when the multiplier bits above iteration k are all zero.
    function automatic logic upper_b_zero(input logic [DATA_W-1:0] b, input logic [K_W-1:0] k);
        logic [5:0] w_sh;
        w_sh = 6'(({2'b00, k} + 6'd1) * 6'(BITS_PER_ITER));
        return (b >> w_sh) == {DATA_W{1'b0}};
    endfunction

endpackage

// File: rtl/mult_pp_gen.sv
// Partial-product selector: the two shifted multiplicand rows for iteration k,
// or the two's-complement correction rows that subtract A64*2^32.
module mult_pp_gen
    import mult_seq_pkg::*;
(
    input  logic [ACC_W-1:0]  i_a64,
    input  logic [DATA_W-1:0] i_b,
    input  logic [K_W-1:0]    i_k,
    input  logic              i_iter,
    input  logic              i_corr,
    output logic [ACC_W-1:0]  o_i3,
    output logic [ACC_W-1:0]  o_i4
);

    logic [4:0] w_bit0;
    logic [4:0] w_bit1;

    assign w_bit0 = {i_k, 1'b0};
    assign w_bit1 = {i_k, 1'b1};

    // Row selection; the correction adds ~(A<<32) + 1, i.e. subtracts A<<32.
    always_comb begin
        o_i3 = {ACC_W{1'b0}};
        o_i4 = {ACC_W{1'b0}};
        if (i_corr) begin
            o_i3 = ~(i_a64 << 6'd32);
            o_i4 = 64'd1;
        end else if (i_iter) begin
            if (i_b[w_bit0]) begin
                o_i3 = i_a64 << w_bit0;
            end else begin
                o_i3 = {ACC_W{1'b0}};
            end
            if (i_b[w_bit1]) begin
                o_i4 = i_a64 << w_bit1;
            end else begin
                o_i4 = {ACC_W{1'b0}};
            end
        end else begin
            o_i3 = {ACC_W{1'b0}};
            o_i4 = {ACC_W{1'b0}};
        end
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential 32x32(+64) multiplier controller driving an external 4:2 compressor row.
// Optional build macro: MULT_EARLY_TERM_EN stops iterating once the remaining multiplier bits are zero.
module mult_seq_ctrl
    import mult_seq_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [DATA_W-1:0] i_op_a,
    input  logic [DATA_W-1:0] i_op_b,
    input  logic [ACC_W-1:0]  i_acc,
    input  logic              i_signed,
    input  logic              i_accum,
    output logic [ACC_W-1:0]  o_cmp_i1,
    output logic [ACC_W-1:0]  o_cmp_i2,
    output logic [ACC_W-1:0]  o_cmp_i3,
    output logic [ACC_W-1:0]  o_cmp_i4,
    output logic [ACC_W-1:0]  o_cmp_ci,
    input  logic [ACC_W-1:0]  i_cmp_c1,
    input  logic [ACC_W-1:0]  i_cmp_s1,
    input  logic [ACC_W-1:0]  i_cmp_s0,
    output logic              o_busy,
    output logic              o_done,
    output logic [ACC_W-1:0]  o_res_sum,
    output logic [ACC_W-1:0]  o_res_carry
);

    state_t              r_state;
    logic [ACC_W-1:0]    r_sum;
    logic [ACC_W-1:0]    r_carry;
    logic [K_W-1:0]      r_k;
    logic [ACC_W-1:0]    r_a64;
    logic [DATA_W-1:0]   r_b;
    logic                r_signed;
    logic                r_busy;
    logic                r_done;

    logic                w_iter;
    logic                w_corr;
    logic                w_last_iter;
    logic                w_need_corr;
    logic [ACC_W-1:0]    w_pp3;
    logic [ACC_W-1:0]    w_pp4;

    assign w_iter      = (r_state == ST_ITER);
    assign w_corr      = (r_state == ST_CORR);
    assign w_need_corr = r_signed & r_b[DATA_W-1];

`ifdef MULT_EARLY_TERM_EN
    assign w_last_iter = (r_k == K_W'(ITER_COUNT - 1)) || upper_b_zero(r_b, r_k);
`else
    assign w_last_iter = (r_k == K_W'(ITER_COUNT - 1));
`endif

    mult_pp_gen u_pp_gen (
        .i_a64  (r_a64),
        .i_b    (r_b),
        .i_k    (r_k),
        .i_iter (w_iter),
        .i_corr (w_corr),
        .o_i3   (w_pp3),
        .o_i4   (w_pp4)
    );

    // Compressor row operands are only live while the row is being accumulated.
    always_comb begin
        o_cmp_i1 = {ACC_W{1'b0}};
        o_cmp_i2 = {ACC_W{1'b0}};
        if (w_iter || w_corr) begin
            o_cmp_i1 = r_sum;
            o_cmp_i2 = r_carry;
        end else begin
            o_cmp_i1 = {ACC_W{1'b0}};
            o_cmp_i2 = {ACC_W{1'b0}};
        end
    end

    assign o_cmp_i3    = w_pp3;
    assign o_cmp_i4    = w_pp4;
    assign o_cmp_ci    = i_cmp_c1 << 6'd1;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_res_sum   = r_sum;
    assign o_res_carry = r_carry;

    // Control FSM with operand latches and the redundant sum/carry accumulator.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_sum    <= {ACC_W{1'b0}};
            r_carry  <= {ACC_W{1'b0}};
            r_k      <= {K_W{1'b0}};
            r_a64    <= {ACC_W{1'b0}};
            r_b      <= {DATA_W{1'b0}};
            r_signed <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state  <= ST_ITER;
                        r_busy   <= 1'b1;
                        r_sum    <= i_accum ? i_acc : {ACC_W{1'b0}};
                        r_carry  <= {ACC_W{1'b0}};
                        r_k      <= {K_W{1'b0}};
                        r_a64    <= {{DATA_W{i_op_a[DATA_W-1] & i_signed}}, i_op_a};
                        r_b      <= i_op_b;
                        r_signed <= i_signed;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_ITER: begin
                    if (i_abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_sum   <= i_cmp_s0;
                        r_carry <= i_cmp_s1 << 6'd1;
                        r_k     <= r_k + K_W'(1);
                        if (w_last_iter) begin
                            if (w_need_corr) begin
                                r_state <= ST_CORR;
                            end else begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_state <= ST_ITER;
                        end
                    end
                end
                ST_CORR: begin
                    if (i_abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_sum   <= i_cmp_s0;
                        r_carry <= i_cmp_s1 << 6'd1;
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: behavioural 4:2 compressor, arithmetic reference product,
// directed cases plus randomized operands. Honours MULT_EARLY_TERM_EN for expected latency.
module tb_mult_seq_ctrl;

    logic        clk;
    logic        i_rst;
    logic        i_start;
    logic        i_abort;
    logic [31:0] i_op_a;
    logic [31:0] i_op_b;
    logic [63:0] i_acc;
    logic        i_signed;
    logic        i_accum;
    logic [63:0] o_cmp_i1, o_cmp_i2, o_cmp_i3, o_cmp_i4, o_cmp_ci;
    logic [63:0] w_c1, w_s1, w_s0, w_t;
    logic        o_busy;
    logic        o_done;
    logic [63:0] o_res_sum;
    logic [63:0] o_res_carry;

    int errors = 0;
    int checks = 0;

    mult_seq_ctrl dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .i_op_a      (i_op_a),
        .i_op_b      (i_op_b),
        .i_acc       (i_acc),
        .i_signed    (i_signed),
        .i_accum     (i_accum),
        .o_cmp_i1    (o_cmp_i1),
        .o_cmp_i2    (o_cmp_i2),
        .o_cmp_i3    (o_cmp_i3),
        .o_cmp_i4    (o_cmp_i4),
        .o_cmp_ci    (o_cmp_ci),
        .i_cmp_c1    (w_c1),
        .i_cmp_s1    (w_s1),
        .i_cmp_s0    (w_s0),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_res_sum   (o_res_sum),
        .o_res_carry (o_res_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // First full-adder stage of the compressor row.
    always_comb begin
        w_t  = o_cmp_i1 ^ o_cmp_i2 ^ o_cmp_i3;
        w_c1 = (o_cmp_i1 & o_cmp_i2) | (o_cmp_i1 & o_cmp_i3) | (o_cmp_i2 & o_cmp_i3);
    end

    // Second full-adder stage, fed by the carry-in the DUT routes back.
    always_comb begin
        w_s0 = w_t ^ o_cmp_i4 ^ o_cmp_ci;
        w_s1 = (w_t & o_cmp_i4) | (w_t & o_cmp_ci) | (o_cmp_i4 & o_cmp_ci);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic [63:0] acc, input logic sg, input logic ac);
        logic [63:0] ea, eb;
        ea = sg ? {{32{a[31]}}, a} : {32'd0, a};
        eb = sg ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb + (ac ? acc : 64'd0);
    endfunction

    // Cycle (relative to acceptance edge t) at which DONE is expected.
    function automatic int exp_done_cycle(input logic [31:0] b, input logic sg);
        int n;
        n = 16;
`ifdef MULT_EARLY_TERM_EN
        n = 1;
        while (n < 16 && (b >> (2 * n)) != 0) n++;
`endif
        return n + ((sg && b[31]) ? 1 : 0) + 1;
    endfunction

    // Issue one operation from a negedge; optional stray START at pulse_n, ABORT at abort_n.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] acc,
                          input logic sg, input logic ac, input int pulse_n, input int abort_n,
                          input string tag);
        int n, done_n, busy_n, exp_n;
        logic [63:0] sav_s, sav_c, exp_r;
        i_op_a = a; i_op_b = b; i_acc = acc; i_signed = sg; i_accum = ac; i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        n = 1; done_n = 0; busy_n = 0; sav_s = 64'd0; sav_c = 64'd0;
        while (n <= 40) begin
            if (o_busy) busy_n++;
            if (o_done) begin
                done_n = n;
                break;
            end
            if (n == pulse_n) begin
                i_start = 1'b1; i_op_a = ~a; i_op_b = ~b; i_signed = ~sg; i_accum = ~ac;
            end
            if (n == abort_n) begin
                sav_s = o_res_sum; sav_c = o_res_carry; i_abort = 1'b1;
            end
            @(negedge clk);
            i_start = 1'b0; i_abort = 1'b0;
            n++;
            if (n - 1 == abort_n) break;
        end
        if (abort_n > 0) begin
            check({tag, "_abort_busy"}, {63'd0, o_busy}, 64'd0);
            check({tag, "_abort_done"}, {63'd0, o_done}, 64'd0);
            check({tag, "_abort_sum"}, o_res_sum, sav_s);
            check({tag, "_abort_carry"}, o_res_carry, sav_c);
            check({tag, "_abort_i1"}, o_cmp_i1, 64'd0);
        end else begin
            exp_n = exp_done_cycle(b, sg);
            exp_r = ref_result(a, b, acc, sg, ac);
            check({tag, "_done_cycle"}, 64'(done_n), 64'(exp_n));
            check({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_n));
            check({tag, "_result"}, o_res_sum + o_res_carry, exp_r);
            @(negedge clk);
            check({tag, "_done_pulse"}, {63'd0, o_done}, 64'd0);
            check({tag, "_busy_after"}, {63'd0, o_busy}, 64'd0);
            check({tag, "_hold"}, o_res_sum + o_res_carry, exp_r);
            check({tag, "_idle_i3"}, o_cmp_i3 | o_cmp_i4, 64'd0);
        end
    endtask

    initial begin
        int done_seen;
        logic [31:0] ra, rb;
        logic [63:0] racc;
        i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0;
        i_op_a = 32'd0; i_op_b = 32'd0; i_acc = 64'd0; i_signed = 1'b0; i_accum = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, o_busy}, 64'd0);
        check("rst_done", {63'd0, o_done}, 64'd0);
        check("rst_sum", o_res_sum, 64'd0);
        check("rst_carry", o_res_carry, 64'd0);
        check("rst_cmp", o_cmp_i1 | o_cmp_i2 | o_cmp_i3 | o_cmp_i4, 64'd0);
        i_rst = 1'b0;
        @(negedge clk);

        run_op(32'd3, 32'd5, 64'd0, 1'b0, 1'b0, 0, 0, "u3x5");
        run_op(32'hFFFFFFFE, 32'd3, 64'd0, 1'b1, 1'b0, 0, 0, "s_m2x3");
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, 1'b0, 1'b0, 0, 0, "u_max");
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, 1'b1, 1'b0, 0, 0, "s_m1");
        run_op(32'd2, 32'd2, 64'h100, 1'b0, 1'b1, 5, 0, "accum");
        run_op(32'h1234_5678, 32'h8000_1234, 64'd0, 1'b0, 1'b0, 0, 8, "abort");
        run_op(32'd9, 32'd11, 64'd0, 1'b0, 1'b0, 0, 0, "after_abort");
        run_op(32'd7, 32'd1, 64'd0, 1'b0, 1'b0, 0, 0, "u7x1");
        run_op(32'h8000_0000, 32'h8000_0000, 64'hDEAD_BEEF_0000_0001, 1'b1, 1'b1, 0, 0, "s_min");
        run_op(32'd0, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 0, 0, "zero_acc");

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 1) == 1) ? $urandom : ($urandom & 32'h0000_00FF);
            racc = {$urandom, $urandom};
            run_op(ra, rb, racc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, "rand");
        end

        i_op_a = 32'd7; i_op_b = 32'h8000_0001; i_signed = 1'b0; i_accum = 1'b0; i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        i_rst = 1'b1;
        #1;
        check("midrst_busy", {63'd0, o_busy}, 64'd0);
        check("midrst_done", {63'd0, o_done}, 64'd0);
        check("midrst_sum", o_res_sum, 64'd0);
        check("midrst_carry", o_res_carry, 64'd0);
        check("midrst_cmp", o_cmp_i1 | o_cmp_i2 | o_cmp_i3 | o_cmp_i4, 64'd0);
        @(negedge clk);
        i_rst = 1'b0;
        done_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_done || o_busy) done_seen++;
        end
        check("midrst_no_done", 64'(done_seen), 64'd0);
        run_op(32'd6, 32'd7, 64'd0, 1'b0, 1'b0, 0, 0, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_seq_ctrl.md
MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports SHALL be listed clock first, then reset.
REQ-002 CLK  in  1  rising-edge clock.
REQ-003 RST  in  1  asynchronous, active-high reset.
REQ-004 START  in  1  request a multiply; accepted only in IDLE.
REQ-005 ABORT  in  1  synchronous cancel of the operation in flight.
REQ-006 OP_A, OP_B  in  32 each  multiplicand and multiplier; sampled when START is accepted.
REQ-007 ACC  in  64  accumulate addend; sampled when START is accepted.
REQ-008 SIGNED, ACCUM  in  1 each  signed operation, accumulate enable; sampled when START is accepted.
REQ-009 CMP_I1..CMP_I4, CMP_CI  out  64 each  operand and carry-in vectors to the 64-bit 4:2 compressor row.
REQ-010 CMP_C1, CMP_S1, CMP_S0  in  64 each  outputs of the compressor row.
REQ-011 BUSY  out  1  high from START acceptance until DONE.
REQ-012 DONE  out  1  one-cycle completion pulse.
REQ-013 RES_SUM, RES_CARRY  out  64 each  redundant result; the product is RES_SUM+RES_CARRY mod 2^64.

Function
REQ-014 The state machine SHALL have four states, with these transitions:
- IDLE -> ITER on START.
- ITER -> CORR or DONE after the last iteration.
- CORR -> DONE.
- DONE -> IDLE.
REQ-015 On START acceptance (edge t), the block SHALL:
- load sum_reg with ACC if ACCUM is set, else 0;
- load carry_reg with 0 and the iteration counter with 0;
- latch A64 as OP_A sign-extended if SIGNED is set, else zero-extended;
- latch OP_B.
REQ-016 In ITER iteration k (0..15), the block SHALL drive:
- CMP_I1=sum_reg, CMP_I2=carry_reg;
- CMP_I3=B[2k] ? A64<<2k : 0;
- CMP_I4=B[2k+1] ? A64<<(2k+1) : 0.
REQ-017 CMP_CI SHALL always be {CMP_C1[62:0],1'b0}.
REQ-018 Each ITER and CORR cycle SHALL capture sum_reg<=CMP_S0 and carry_reg<={CMP_S1[62:0],1'b0}.
REQ-019 CORR SHALL occur only when SIGNED and B[31] are both set; it SHALL drive CMP_I3=~(A64<<32) and CMP_I4=64'h1, i.e. subtract A64*2^32.
REQ-020 Without early termination, ITER SHALL occupy cycles t+1..t+16; CORR, if needed, SHALL be t+17; DONE SHALL be high in the following cycle (t+17 or t+18).
REQ-021 Outside ITER and CORR, CMP_I1..I4 SHALL be driven to 0.
REQ-022 RES_SUM and RES_CARRY SHALL mirror sum_reg and carry_reg, and SHALL hold until the next START is accepted.
REQ-023 BUSY SHALL be high in ITER, CORR and DONE.
REQ-024 START while BUSY SHALL be ignored; START in the DONE cycle SHALL be ignored.
REQ-025 ABORT in any non-IDLE state SHALL go to IDLE next cycle, with no DONE and the result registers unchanged.
REQ-026 If START and ABORT are both asserted in IDLE, START SHALL win.

Reset
REQ-027 RST SHALL asynchronously force:
- state=IDLE, BUSY=0, DONE=0;
- sum_reg=0, carry_reg=0, counter=0, latched operands=0.
REQ-028 RST asserted mid-operation SHALL discard the operation with no DONE.

Configuration
REQ-029 With MULT_EARLY_TERM_EN defined, ITER SHALL end after iteration k when B[31:2k+2] are all zero; CORR still follows if required.
REQ-030 Without MULT_EARLY_TERM_EN, all 16 iterations SHALL always run.

Structure
REQ-031 Package mult_seq_pkg SHALL hold:
- the state enum;
- ITER_COUNT=16, BITS_PER_ITER=2, DATA_W=32, ACC_W=64.
REQ-032 Sub-module mult_pp_gen SHALL form CMP_I3/CMP_I4 from A64, B and k, including the CORR vectors.

Verification
REQ-033 Unsigned, A=3, B=5, ACCUM=0 -> sum+carry=64'hF, DONE at t+17, BUSY high for 17 cycles.
REQ-034 Signed, A=32'hFFFFFFFE, B=3 -> 64'hFFFFFFFFFFFFFFFA, no CORR, DONE at t+17.
REQ-035 A=B=32'hFFFFFFFF:
- unsigned -> 64'hFFFFFFFE00000001, DONE at t+17;
- signed -> 64'h1, DONE at t+18.
REQ-036 ACCUM=1, ACC=64'h100, A=2, B=2 -> 64'h104; START pulsed at t+5 is ignored.
REQ-037 ABORT at t+8 -> IDLE at t+9, no DONE, RES_* unchanged; a new START at t+9 completes normally.
REQ-038 With MULT_EARLY_TERM_EN, unsigned B=1, A=7 -> 64'h7, DONE at t+2; RST asserted at t+1 of a second operation -> immediate IDLE, outputs 0.
